spi_param_rx: RTL

- SPI slave (mode 0, CPOL=0/CPHA=0) that receives sweep-parameter frames from the host MCU.
- Holds the four sweep registers: SPI_fre_start, SPI_fre_end, SPI_step, SPI_cycle. These feed the key-controlled sweep/wave-select block.
- Oversamples SCLK/CS/MOSI in the system clock domain. Signals parameter updates with a one-cycle strobe.

---
 rtl/spi_param_rx_if.sv | 29 ++
 rtl/spi_param_rx.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/spi_param_rx_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : spi_param_rx_if
//  Description : SPI pin bundle between the host MCU (master) and the
//                sweep-parameter receiver (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface spi_param_rx_if;
  logic spi_sclk;
  logic spi_cs_n;
  logic spi_mosi;
  logic spi_miso;

  modport master (
    output spi_sclk,
    output spi_cs_n,
    output spi_mosi,
    input  spi_miso
  );

  modport slave (
    input  spi_sclk,
    input  spi_cs_n,
    input  spi_mosi,
    output spi_miso
  );
endinterface
`default_nettype wire

// File: rtl/spi_param_rx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : spi_param_rx
//  Description : Mode-0 SPI slave receiving 40-bit sweep-parameter frames
//                (8-bit command + 32-bit data, MSB first). SPI pins are
//                oversampled in the clk domain. Holds the four sweep
//                registers and strobes upd_pulse / frame_err.
//  Option      : define SPI_READBACK_EN to return the pre-write value of the
//                addressed register on spi_miso during the data phase.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_param_rx #(
  parameter int          SYNC_STAGES   = 2,
  parameter logic [31:0] RST_FRE_START = 32'd34300,
  parameter logic [31:0] RST_FRE_END   = 32'd343000,
  parameter logic [31:0] RST_STEP      = 32'd343,
  parameter logic [31:0] RST_CYCLE     = 32'd4999999
) (
  input  logic        clk,
  input  logic        rst_n,
  spi_param_rx_if.slave spi,
  output logic [31:0] SPI_fre_start,
  output logic [31:0] SPI_fre_end,
  output logic [31:0] SPI_step,
  output logic [31:0] SPI_cycle,
  output logic        upd_pulse,
  output logic [1:0]  upd_addr,
  output logic        frame_err
);

  // A single flop cannot be trusted against metastability, so clamp depth.
  localparam int c_SYNC_DEPTH = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  typedef enum logic [2:0] {
    S_WAIT_CS_HIGH = 3'd0,
    S_IDLE         = 3'd1,
    S_CMD          = 3'd2,
    S_DATA         = 3'd3,
    S_COMMIT       = 3'd4
  } state_t;

  logic [c_SYNC_DEPTH-1:0] r_sclk_sync;
  logic [c_SYNC_DEPTH-1:0] r_cs_sync;
  logic [c_SYNC_DEPTH-1:0] r_mosi_sync;
  logic                    r_sclk_prev;

  state_t      r_state;
  logic [5:0]  r_bit_cnt;
  logic [39:0] r_shift;
  logic [31:0] r_regs [0:3];
  logic        r_upd_pulse;
  logic [1:0]  r_upd_addr;
  logic        r_frame_err;

  logic        w_sclk;
  logic        w_cs_n;
  logic        w_mosi;
  logic        w_rise;
  logic [39:0] w_shift_next;
  logic        w_wr;
  logic [4:0]  w_rsv;
  logic [1:0]  w_idx;
  logic [31:0] w_wdata;

  assign w_sclk       = r_sclk_sync[c_SYNC_DEPTH-1];
  assign w_cs_n       = r_cs_sync[c_SYNC_DEPTH-1];
  assign w_mosi       = r_mosi_sync[c_SYNC_DEPTH-1];
  assign w_rise       = w_sclk & ~r_sclk_prev;
  assign w_shift_next = {r_shift[38:0], w_mosi};

  // Command fields as they sit in the fully shifted frame.
  assign w_wr    = r_shift[39];
  assign w_rsv   = r_shift[38:34];
  assign w_idx   = r_shift[33:32];
  assign w_wdata = r_shift[31:0];

  // Synchronizers; cs resets low so a frame in flight at reset is never
  // mistaken for a fresh CS-high period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sclk_sync <= '0;
      r_cs_sync   <= '0;
      r_mosi_sync <= '0;
      r_sclk_prev <= 1'b0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[c_SYNC_DEPTH-2:0], spi.spi_sclk};
      r_cs_sync   <= {r_cs_sync[c_SYNC_DEPTH-2:0],   spi.spi_cs_n};
      r_mosi_sync <= {r_mosi_sync[c_SYNC_DEPTH-2:0], spi.spi_mosi};
      r_sclk_prev <= w_sclk;
    end
  end

  // Frame FSM: shift 40 bits, then commit or reject in one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_WAIT_CS_HIGH;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_regs[0]   <= RST_FRE_START;
      r_regs[1]   <= RST_FRE_END;
      r_regs[2]   <= RST_STEP;
      r_regs[3]   <= RST_CYCLE;
      r_upd_pulse <= 1'b0;
      r_upd_addr  <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_upd_pulse <= 1'b0;
      r_frame_err <= 1'b0;
      case (r_state)
        S_WAIT_CS_HIGH: begin
          if (w_cs_n) r_state <= S_IDLE;
        end
        S_IDLE: begin
          if (!w_cs_n) begin
            r_state   <= S_CMD;
            r_bit_cnt <= '0;
          end
        end
        S_CMD, S_DATA: begin
          if (w_cs_n) begin
            // Short frame: drop it without touching any register.
            r_frame_err <= 1'b1;
            r_state     <= S_IDLE;
          end else if (w_rise) begin
            r_shift   <= w_shift_next;
            r_bit_cnt <= r_bit_cnt + 6'd1;
            if (r_bit_cnt == 6'd7)       r_state <= S_DATA;
            else if (r_bit_cnt == 6'd39) r_state <= S_COMMIT;
          end
        end
        S_COMMIT: begin
          if (w_rsv != 5'd0) begin
            r_frame_err <= 1'b1;
          end else if (w_wr) begin
            r_regs[w_idx] <= w_wdata;
            r_upd_pulse   <= 1'b1;
            r_upd_addr    <= w_idx;
          end
          r_state <= S_WAIT_CS_HIGH;
        end
        default: r_state <= S_WAIT_CS_HIGH;
      endcase
    end
  end

`ifdef SPI_READBACK_EN
  logic        w_fall;
  logic [31:0] r_tx;

  assign w_fall = ~w_sclk & r_sclk_prev;

  // TX shifter: load on the 8th rise, then present the next bit after each
  // fall that follows a data-bit rise so bit31 is stable for the 9th rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx <= '0;
    end else if (r_state == S_CMD && !w_cs_n && w_rise && r_bit_cnt == 6'd7) begin
      r_tx <= r_regs[w_shift_next[1:0]];
    end else if (r_state == S_DATA && !w_cs_n) begin
      if (w_fall && r_bit_cnt > 6'd8) r_tx <= {r_tx[30:0], 1'b0};
    end else begin
      r_tx <= '0;
    end
  end

  assign spi.spi_miso = r_tx[31];
`else
  assign spi.spi_miso = 1'b0;
`endif

  assign SPI_fre_start = r_regs[0];
  assign SPI_fre_end   = r_regs[1];
  assign SPI_step      = r_regs[2];
  assign SPI_cycle     = r_regs[3];
  assign upd_pulse     = r_upd_pulse;
  assign upd_addr      = r_upd_addr;
  assign frame_err     = r_frame_err;

endmodule
`default_nettype wire
